// File: rtl/pwr_seq_ctrl.sv
// Power/reset sequencer for N downstream channels: ascending power-up gated
// by power-good with timeout, descending orderly power-down, emergency
// all-off with backoff and bounded retries, then lock-out.
module pwr_seq_ctrl #(
  parameter int N          = 4,
  parameter int tSTEP      = 1000000,
  parameter int tPG        = 5000000,
  parameter int tRETRY     = 10000000,
  parameter int MAX_RETRY  = 3,
  parameter int AUTO_START = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] ch_pgood,
  output logic [N-1:0] ch_on,
  output logic [N-1:0] ch_off,
  output logic         all_up,
  output logic         busy,
  output logic         fault,
  output logic [2:0]   fault_ch,
  output logic [3:0]   retry_cnt
);

  typedef enum logic [2:0] {
    IDLE, UP_WAIT, UP_GAP, RUN, DOWN, BACKOFF, LOCK
  } state_t;

  localparam logic [2:0]  LAST_CH   = 3'(N - 1);
  localparam logic [31:0] STEP_END  = 32'(tSTEP - 1);
  localparam logic [31:0] PG_END    = 32'(tPG - 1);
  localparam logic [31:0] RETRY_END = 32'(tRETRY - 1);
  localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [31:0] timer, timer_nxt;
  logic [N-1:0] ch_on_nxt, ch_off_nxt;
  logic        fault_nxt;
  logic [2:0]  fault_ch_nxt;
  logic [3:0]  retry_nxt;
  logic        auto_pending;
  logic        start_eff;
  logic        pg_cur;
  logic        pg_fault;
  logic [2:0]  pg_fault_ch;
  logic        fault_evt;
  logic [2:0]  fault_idx;
  logic [N-1:0] mon_mask;
  logic [N-1:0] bad_pg;

  // One-hot channel vector; indices at or beyond N select nothing.
  function automatic logic [N-1:0] onehot(input logic [2:0] i);
    onehot = '0;
    for (int k = 0; k < N; k++) onehot[k] = (3'(k) == i);
  endfunction

  assign start_eff = start | auto_pending;

  // Power-good watchdog: channels already confirmed up must stay up; the
  // lowest failing channel is the one reported.
  always_comb begin
    mon_mask    = '0;
    pg_cur      = 1'b0;
    pg_fault_ch = 3'd0;
    for (int k = 0; k < N; k++) begin
      if (3'(k) == idx) pg_cur = ch_pgood[k];
      unique case (state)
        UP_WAIT: mon_mask[k] = (3'(k) < idx);
        UP_GAP:  mon_mask[k] = (3'(k) <= idx);
        RUN:     mon_mask[k] = 1'b1;
        default: mon_mask[k] = 1'b0;
      endcase
    end
    bad_pg   = mon_mask & ~ch_pgood;
    pg_fault = |bad_pg;
    for (int k = N - 1; k >= 0; k--) begin
      if (bad_pg[k]) pg_fault_ch = 3'(k);
    end
    fault_evt = pg_fault | ((state == UP_WAIT) && !pg_cur && (timer == PG_END));
    fault_idx = pg_fault ? pg_fault_ch : idx;
  end

  // State register plus all datapath registers and registered pulse outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      idx          <= 3'd0;
      timer        <= 32'd0;
      ch_on        <= '0;
      ch_off       <= '0;
      fault        <= 1'b0;
      fault_ch     <= 3'd0;
      retry_cnt    <= 4'd0;
      auto_pending <= (AUTO_START != 0);
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      timer        <= timer_nxt;
      ch_on        <= ch_on_nxt;
      ch_off       <= ch_off_nxt;
      fault        <= fault_nxt;
      fault_ch     <= fault_ch_nxt;
      retry_cnt    <= retry_nxt;
      auto_pending <= 1'b0;
    end
  end

  // Next-state logic: fault beats stop, stop beats sequence progress.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    timer_nxt    = timer;
    ch_on_nxt    = '0;
    ch_off_nxt   = '0;
    fault_nxt    = fault;
    fault_ch_nxt = fault_ch;
    retry_nxt    = retry_cnt;
    unique case (state)
      IDLE, LOCK: begin
        if (start_eff && !stop) begin
          fault_nxt    = 1'b0;
          fault_ch_nxt = 3'd0;
          retry_nxt    = 4'd0;
          idx_nxt      = 3'd0;
          timer_nxt    = 32'd0;
          ch_on_nxt    = onehot(3'd0);
          state_nxt    = UP_WAIT;
        end
      end
      UP_WAIT, UP_GAP, RUN: begin
        if (fault_evt) begin
          fault_nxt    = 1'b1;
          fault_ch_nxt = fault_idx;
          ch_off_nxt   = '1;
          idx_nxt      = 3'd0;
          timer_nxt    = 32'd0;
          state_nxt    = (retry_cnt < RETRY_LIM) ? BACKOFF : LOCK;
        end else if (stop) begin
          ch_off_nxt = onehot(idx);
          timer_nxt  = 32'd0;
          state_nxt  = DOWN;
        end else if (state == UP_WAIT) begin
          timer_nxt = timer + 32'd1;
          if (pg_cur) begin
            timer_nxt = 32'd0;
            if (idx == LAST_CH) begin
              retry_nxt = 4'd0;
              state_nxt = RUN;
            end else begin
              state_nxt = UP_GAP;
            end
          end
        end else if (state == UP_GAP) begin
          timer_nxt = timer + 32'd1;
          if (timer == STEP_END) begin
            idx_nxt   = idx + 3'd1;
            ch_on_nxt = onehot(idx + 3'd1);
            timer_nxt = 32'd0;
            state_nxt = UP_WAIT;
          end
        end
      end
      DOWN: begin
        timer_nxt = timer + 32'd1;
        if (timer == STEP_END) begin
          timer_nxt = 32'd0;
          if (idx == 3'd0) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt    = idx - 3'd1;
            ch_off_nxt = onehot(idx - 3'd1);
          end
        end
      end
      BACKOFF: begin
        timer_nxt = timer + 32'd1;
        if (stop) begin
          timer_nxt = 32'd0;
          state_nxt = IDLE;
        end else if (timer == RETRY_END) begin
          retry_nxt = retry_cnt + 4'd1;
          ch_on_nxt = onehot(3'd0);
          timer_nxt = 32'd0;
          state_nxt = UP_WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    all_up = (state == RUN);
    busy   = (state == UP_WAIT) || (state == UP_GAP) ||
             (state == DOWN)    || (state == BACKOFF);
  end

endmodule
